seq_control: RTL and testbench

Parametrised program sequencer for the cellular-automaton processor core. It decodes the 4-bit opcode field of the current 16-bit instruction and produces the next program counter. It also maintains a bounded call stack with overflow/underflow detection, a pipeline stall input, and a halt/fault state. It sits between instruction memory (which it addresses) and the SIMD cell array (which supplies diverge_consensus).

---
 rtl/ca_isa_pkg.sv | 16 +
 rtl/seq_pkg.sv | 19 +
 rtl/seq_call_stack.sv | 64 ++++++
 rtl/seq_control.sv | 149 ++++++++++++++
 tb/tb_seq_control.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ca_isa_pkg.sv
// Shared ISA constants for the cellular-automaton processor core.
// Opcodes occupy instruction[15:12]; every unlisted encoding behaves as a sequential fetch.
package ca_isa_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_NOP  = 4'h0;
    localparam opcode_t OP_JUMP = 4'h1;
    localparam opcode_t OP_UNL  = 4'h2;
    localparam opcode_t OP_CALL = 4'h3;
    localparam opcode_t OP_RET  = 4'h4;
    localparam opcode_t OP_HALT = 4'h5;
    localparam opcode_t OP_LDC  = 4'h6;
    localparam opcode_t OP_DBNZ = 4'h7;

endpackage

// File: rtl/seq_pkg.sv
// Sequencer-local types: run/halt state and the stack fault code reported on halt.
package seq_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } seq_state_e;

    typedef enum logic [1:0] {
        FC_NONE = 2'd0,
        FC_OVF  = 2'd1,
        FC_UNF  = 2'd2
    } fault_code_e;

    function automatic logic [3:0] get_opcode(input logic [15:0] instr);
        return instr[15:12];
    endfunction

endpackage

// File: rtl/seq_call_stack.sv
// Return-address LIFO for the sequencer: push/pop with full/empty flags and a read port at SP-1.
// The pointer counts entries (0..DEPTH); entry storage is deliberately not reset.
module seq_call_stack #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 32,
    parameter int SP_W   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] push_data_i,
    output logic [SP_W-1:0]   sp_next_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W-1:0] top_o
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [SP_W-1:0]   sp_q;
    logic [SP_W-1:0]   sp_d;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (sp_q == SP_W'(DEPTH));
    assign empty_o = (sp_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o && !push_i;

    // DEPTH is a power of two, so the low pointer bits index the array and SP-1 wraps correctly when full.
    assign wr_idx = sp_q[IDX_W-1:0];
    assign rd_idx = wr_idx - IDX_W'(1);

    always_comb begin
        sp_d = sp_q;
        if (do_push) begin
            sp_d = sp_q + SP_W'(1);
        end else if (do_pop) begin
            sp_d = sp_q - SP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= push_data_i;
        end
    end

    assign top_o     = mem_q[rd_idx];
    assign sp_next_o = sp_d;

endmodule

// File: rtl/seq_control.sv
// Program sequencer: decodes the opcode, produces the next PC, manages the call stack and halt/fault state.
// Optional hardware loop counter (LDC/DBNZ) is enabled by defining SEQ_CONTROL_LOOP_EN.
module seq_control
    import ca_isa_pkg::*;
    import seq_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int STACK_DEPTH = 32,
    parameter int PC_STEP     = 2,
    parameter int SP_W        = $clog2(STACK_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       instruction,
    input  logic              stall,
    input  logic              diverge_consensus,
    output logic [ADDR_W-1:0] program_counter,
    output logic [ADDR_W-1:0] next_program_counter,
    output logic [SP_W-1:0]   next_stack_pointer,
    output logic              halted,
    output logic              fault,
    output logic [1:0]        fault_code
);

    seq_state_e        state_q, state_d;
    fault_code_e       code_q, code_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] pc_plus;
    logic [ADDR_W-1:0] jump_addr;
    logic [ADDR_W-1:0] imm_addr;
    logic [3:0]        opcode;
    logic              push;
    logic              pop;
    logic              stack_full;
    logic              stack_empty;
    logic [ADDR_W-1:0] stack_top;
`ifdef SEQ_CONTROL_LOOP_EN
    logic [ADDR_W-1:0] loop_q, loop_d;
`endif

    // Truncating additions give the modulo-2^ADDR_W wrap for both fetch and pushed return address.
    assign pc_plus   = pc_q + ADDR_W'(PC_STEP);
    assign jump_addr = ADDR_W'(instruction[11:0]);
    assign imm_addr  = ADDR_W'(instruction[7:0]);
    assign opcode    = get_opcode(instruction);

    seq_call_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (STACK_DEPTH),
        .SP_W   (SP_W)
    ) u_stack (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (pc_plus),
        .sp_next_o   (next_stack_pointer),
        .full_o      (stack_full),
        .empty_o     (stack_empty),
        .top_o       (stack_top)
    );

    // Stall and the HALT state both leave every default in place, so nothing moves and no fault is raised.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        code_d  = code_q;
        push    = 1'b0;
        pop     = 1'b0;
`ifdef SEQ_CONTROL_LOOP_EN
        loop_d  = loop_q;
`endif
        if (state_q == RUN && !stall) begin
            case (opcode)
                OP_JUMP: pc_d = jump_addr;
                OP_UNL:  pc_d = diverge_consensus ? imm_addr : pc_plus;
                OP_CALL: begin
                    if (!stack_full) begin
                        push = 1'b1;
                        pc_d = jump_addr;
                    end else begin
                        state_d = HALT;
                        fault_d = 1'b1;
                        code_d  = FC_OVF;
                    end
                end
                OP_RET: begin
                    if (!stack_empty) begin
                        pop  = 1'b1;
                        pc_d = stack_top;
                    end else begin
                        state_d = HALT;
                        fault_d = 1'b1;
                        code_d  = FC_UNF;
                    end
                end
                OP_HALT: begin
                    state_d = HALT;
                    fault_d = 1'b0;
                    code_d  = FC_NONE;
                end
`ifdef SEQ_CONTROL_LOOP_EN
                OP_LDC: begin
                    loop_d = imm_addr;
                    pc_d   = pc_plus;
                end
                OP_DBNZ: begin
                    pc_d   = (loop_q > ADDR_W'(1)) ? imm_addr : pc_plus;
                    loop_d = (loop_q == '0) ? '0 : loop_q - ADDR_W'(1);
                end
`endif
                default: pc_d = pc_plus;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= '0;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end

`ifdef SEQ_CONTROL_LOOP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            loop_q <= '0;
        end else begin
            loop_q <= loop_d;
        end
    end
`endif

    assign program_counter      = pc_q;
    assign next_program_counter = pc_d;
    assign halted               = (state_q == HALT);
    assign fault                = fault_q;
    assign fault_code           = code_q;

endmodule

// File: tb/tb_seq_control.sv
// Self-checking bench for seq_control (STACK_DEPTH=4): vector table, corner sequences, random run vs. queue model.
// Covers the SEQ_CONTROL_LOOP_EN build as well when that macro is defined.
module tb_seq_control;
    import ca_isa_pkg::*;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 4;
    localparam int STEP   = 2;
    localparam int SPW    = $clog2(DEPTH) + 1;
    localparam int AMOD   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [15:0]       instruction = 16'h0000;
    logic              stall = 1'b0;
    logic              diverge_consensus = 1'b0;
    logic [ADDR_W-1:0] program_counter;
    logic [ADDR_W-1:0] next_program_counter;
    logic [SPW-1:0]    next_stack_pointer;
    logic              halted;
    logic              fault;
    logic [1:0]        fault_code;

    seq_control #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (DEPTH),
        .PC_STEP     (STEP),
        .SP_W        (SPW)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .instruction          (instruction),
        .stall                (stall),
        .diverge_consensus    (diverge_consensus),
        .program_counter      (program_counter),
        .next_program_counter (next_program_counter),
        .next_stack_pointer   (next_stack_pointer),
        .halted               (halted),
        .fault                (fault),
        .fault_code           (fault_code)
    );

    always #5 clk = ~clk;

    int tests    = 0;
    int failures = 0;
    int lastNextSp;

    // Behavioural model: architectural state with the call stack as a queue.
    int mPc;
    int mStack[$];
    bit mHalted;
    bit mFault;
    int mCode;
    int mLoop;

    int pPc;
    bit pPush;
    bit pPop;
    int pPushVal;
    bit pHalted;
    bit pFault;
    int pCode;
    int pLoop;

    typedef struct {
        logic [15:0] ins;
        bit          st;
        bit          cons;
        int          expPc;
        int          expSp;
        bit          expHalted;
        bit          expFault;
        int          expCode;
    } vec_t;

    task automatic checkOutput(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic modelReset();
        mPc = 0;
        mStack.delete();
        mHalted = 1'b0;
        mFault = 1'b0;
        mCode = 0;
        mLoop = 0;
    endtask

    task automatic modelPredict(input logic [15:0] ins, input bit st, input bit cons);
        int inc;
        int jmp;
        int imm;
        pPc = mPc;
        pPush = 1'b0;
        pPop = 1'b0;
        pPushVal = 0;
        pHalted = mHalted;
        pFault = mFault;
        pCode = mCode;
        pLoop = mLoop;
        if (mHalted || st) return;
        inc = (mPc + STEP) % AMOD;
        jmp = int'(ins[11:0]) % AMOD;
        imm = int'(ins[7:0]);
        case (ins[15:12])
            OP_JUMP: pPc = jmp;
            OP_UNL:  pPc = cons ? imm : inc;
            OP_CALL: begin
                if (mStack.size() < DEPTH) begin
                    pPush = 1'b1;
                    pPushVal = inc;
                    pPc = jmp;
                end else begin
                    pHalted = 1'b1; pFault = 1'b1; pCode = 1;
                end
            end
            OP_RET: begin
                if (mStack.size() > 0) begin
                    pPop = 1'b1;
                    pPc = mStack[$];
                end else begin
                    pHalted = 1'b1; pFault = 1'b1; pCode = 2;
                end
            end
            OP_HALT: begin
                pHalted = 1'b1; pFault = 1'b0; pCode = 0;
            end
`ifdef SEQ_CONTROL_LOOP_EN
            OP_LDC: begin
                pLoop = imm;
                pPc = inc;
            end
            OP_DBNZ: begin
                pPc = (mLoop > 1) ? imm : inc;
                pLoop = (mLoop > 0) ? mLoop - 1 : 0;
            end
`endif
            default: pPc = inc;
        endcase
    endtask

    task automatic modelCommit();
        mPc = pPc;
        if (pPush) mStack.push_back(pPushVal);
        if (pPop) void'(mStack.pop_back());
        mHalted = pHalted;
        mFault = pFault;
        mCode = pCode;
        mLoop = pLoop;
    endtask

    task automatic applyReset(input string nm);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        checkOutput({nm, ".pc"}, int'(program_counter), 0);
        checkOutput({nm, ".halted"}, int'(halted), 0);
        checkOutput({nm, ".fault"}, int'(fault), 0);
        checkOutput({nm, ".code"}, int'(fault_code), 0);
    endtask

    // One instruction: drive, check combinational next_* against the model, clock, check registers.
    task automatic applyStimulus(input string nm, input logic [15:0] ins, input bit st, input bit cons);
        int expSp;
        @(negedge clk);
        instruction = ins;
        stall = st;
        diverge_consensus = cons;
        #1;
        modelPredict(ins, st, cons);
        expSp = mStack.size() + (pPush ? 1 : 0) - (pPop ? 1 : 0);
        lastNextSp = int'(next_stack_pointer);
        checkOutput({nm, ".nextPc"}, int'(next_program_counter), pPc);
        checkOutput({nm, ".nextSp"}, lastNextSp, expSp);
        @(posedge clk);
        #1;
        modelCommit();
        checkOutput({nm, ".pc"}, int'(program_counter), mPc);
        checkOutput({nm, ".halted"}, int'(halted), int'(mHalted));
        checkOutput({nm, ".fault"}, int'(fault), int'(mFault));
        checkOutput({nm, ".code"}, int'(fault_code), mCode);
    endtask

    vec_t vecs[$];

    initial begin
        int bodyCount;
        logic [3:0] rop;

        // Hand-derived expectations (registered values after each edge, next SP before it).
        vecs.push_back('{16'h0000, 0, 0, 16'h002, 0, 0, 0, 0});
        vecs.push_back('{16'h0000, 0, 0, 16'h004, 0, 0, 0, 0});
        vecs.push_back('{16'h0000, 0, 0, 16'h006, 0, 0, 0, 0});
        vecs.push_back('{16'h1010, 0, 0, 16'h010, 0, 0, 0, 0});
        vecs.push_back('{16'h3100, 0, 0, 16'h100, 1, 0, 0, 0});
        vecs.push_back('{16'h4000, 0, 0, 16'h012, 0, 0, 0, 0});
        vecs.push_back('{16'h2040, 0, 1, 16'h040, 0, 0, 0, 0});
        vecs.push_back('{16'h2040, 0, 0, 16'h042, 0, 0, 0, 0});
        vecs.push_back('{16'h3200, 1, 0, 16'h042, 0, 0, 0, 0});
        vecs.push_back('{16'h3200, 1, 0, 16'h042, 0, 0, 0, 0});
        vecs.push_back('{16'h3200, 1, 0, 16'h042, 0, 0, 0, 0});
        vecs.push_back('{16'h3200, 0, 0, 16'h200, 1, 0, 0, 0});
        vecs.push_back('{16'h4000, 0, 0, 16'h044, 0, 0, 0, 0});
        vecs.push_back('{16'h1FFE, 0, 0, 16'hFFE, 0, 0, 0, 0});
        vecs.push_back('{16'h0000, 0, 0, 16'h000, 0, 0, 0, 0});
        vecs.push_back('{16'h4000, 0, 0, 16'h000, 0, 1, 1, 2});
        vecs.push_back('{16'h1123, 0, 0, 16'h000, 0, 1, 1, 2});

        applyReset("reset0");
        for (int i = 0; i < vecs.size(); i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            applyStimulus(nm, vecs[i].ins, vecs[i].st, vecs[i].cons);
            checkOutput({nm, ".tblNextSp"}, lastNextSp, vecs[i].expSp);
            checkOutput({nm, ".tblPc"}, int'(program_counter), vecs[i].expPc);
            checkOutput({nm, ".tblHalted"}, int'(halted), int'(vecs[i].expHalted));
            checkOutput({nm, ".tblFault"}, int'(fault), int'(vecs[i].expFault));
            checkOutput({nm, ".tblCode"}, int'(fault_code), vecs[i].expCode);
        end

        // Overflow: four nested calls fit, the fifth faults with the PC frozen at its call site.
        applyReset("reset1");
        applyStimulus("ovf.jump", 16'h1010, 0, 0);
        applyStimulus("ovf.call1", 16'h3020, 0, 0);
        applyStimulus("ovf.call2", 16'h3030, 0, 0);
        applyStimulus("ovf.call3", 16'h3040, 0, 0);
        applyStimulus("ovf.call4", 16'h3050, 0, 0);
        checkOutput("ovf.sp4", lastNextSp, 4);
        applyStimulus("ovf.call5", 16'h3060, 0, 0);
        checkOutput("ovf.halted", int'(halted), 1);
        checkOutput("ovf.fault", int'(fault), 1);
        checkOutput("ovf.code", int'(fault_code), 1);
        checkOutput("ovf.pc", int'(program_counter), 16'h050);
        applyStimulus("ovf.frozen", 16'h1123, 0, 1);
        checkOutput("ovf.stillPc", int'(program_counter), 16'h050);
        applyReset("reset2");

        // HALT opcode is a clean halt.
        applyStimulus("halt.nop", 16'h0000, 0, 0);
        applyStimulus("halt.op", 16'h5000, 0, 0);
        checkOutput("halt.halted", int'(halted), 1);
        checkOutput("halt.fault", int'(fault), 0);
        checkOutput("halt.pc", int'(program_counter), 2);

        // Pushed return address wraps at the top of the address space.
        applyReset("reset3");
        applyStimulus("wrap.jump", 16'h1FFE, 0, 0);
        applyStimulus("wrap.call", 16'h3100, 0, 0);
        applyStimulus("wrap.ret", 16'h4000, 0, 0);
        checkOutput("wrap.retPc", int'(program_counter), 0);

        // Reset while a CALL is presented returns to PC 0 with an empty stack.
        applyStimulus("mid.call", 16'h3300, 0, 0);
        instruction = 16'h3300;
        applyReset("reset4");
        applyStimulus("mid.stall", 16'h3300, 1, 0);
        checkOutput("mid.sp", lastNextSp, 0);

`ifdef SEQ_CONTROL_LOOP_EN
        applyReset("reset5");
        applyStimulus("loop.ldc", 16'h6003, 0, 0);
        bodyCount = 0;
        for (int i = 0; i < 12 && (mPc == 2 || mPc == 4); i++) begin
            if (mPc == 2) begin
                bodyCount++;
                applyStimulus("loop.body", 16'h0000, 0, 0);
            end else begin
                applyStimulus("loop.dbnz", 16'h7002, 0, 0);
            end
        end
        checkOutput("loop.bodyCount", bodyCount, 3);
        checkOutput("loop.exitPc", int'(program_counter), 6);
        applyStimulus("loop.dbnzZero", 16'h7002, 0, 0);
        checkOutput("loop.zeroPc", int'(program_counter), 8);
`else
        applyReset("reset5");
        bodyCount = 0;
        applyStimulus("noloop.ldc", 16'h6003, 0, 0);
        applyStimulus("noloop.dbnz", 16'h7002, 0, 0);
        checkOutput("noloop.pc", int'(program_counter), 4);
`endif

        // Random run against the model; reset eventually after any halt.
        applyReset("reset6");
        for (int i = 0; i < 400; i++) begin
            if (mHalted && $urandom_range(0, 2) == 0) begin
                applyReset("rndReset");
            end
            rop = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) rop = 4'($urandom_range(0, 15));
            applyStimulus($sformatf("rnd%0d", i), {rop, 12'($urandom)},
                          $urandom_range(0, 4) == 0, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
